// File: rtl/des_pkg.sv
// Shared DES constants, FSM state type, S-box/P tables and small lookup helpers
// used by the iterative Feistel engine.
package des_pkg;

    localparam int unsigned DES_BLOCK_W = 64;
    localparam int unsigned DES_HALF_W  = 32;
    localparam int unsigned DES_KEY_W   = 48;
    localparam int unsigned DES_ROUNDS  = 16;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // One 256-bit word per S-box; entry (row*16 + col) is the nibble at [255-4*idx -: 4].
    localparam logic [255:0] DES_SBOX [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // P permutation, 1-based source bit (bit 1 = MSB) for each output bit, MSB first.
    localparam int unsigned DES_P [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };

    // Zero-based slot in the packed key bus used by a given round.
    function automatic int unsigned key_index(input int unsigned round, input logic decrypt,
                                              input int unsigned num_rounds);
        return decrypt ? (num_rounds - 1 - round) : round;
    endfunction

    function automatic logic [3:0] sbox_lookup(input int unsigned box, input logic [5:0] six);
        int unsigned idx;
        idx = {26'd0, six[5], six[0], six[4:1]};
        return DES_SBOX[box][255 - 4 * idx -: 4];
    endfunction

endpackage

// File: rtl/des_round_slice.sv
// One combinational DES Feistel round: L' = R, R' = L ^ f(R, key).
module des_round_slice
    import des_pkg::*;
(
    input  logic [DES_BLOCK_W-1:0] blk,
    input  logic [DES_KEY_W-1:0]   key,
    output logic [DES_BLOCK_W-1:0] nxt
);

    logic [DES_HALF_W-1:0] r;
    logic [DES_HALF_W+1:0] ext;
    logic [5:0]            six;
    logic [DES_HALF_W-1:0] sbox_out;
    logic [DES_HALF_W-1:0] f_out;

    always_comb begin
        r        = blk[DES_HALF_W-1:0];
        // E expansion: each 6-bit group is a 4-bit stride window over R wrapped at both ends.
        ext      = {r[0], r, r[DES_HALF_W-1]};
        six      = '0;
        sbox_out = '0;
        f_out    = '0;
        for (int unsigned g = 0; g < 8; g++) begin
            six = ext[33 - 4 * g -: 6] ^ key[47 - 6 * g -: 6];
            sbox_out[31 - 4 * g -: 4] = sbox_lookup(g, six);
        end
        for (int unsigned i = 0; i < 32; i++) begin
            f_out[31 - i] = sbox_out[32 - DES_P[i]];
        end
        nxt = {r, blk[DES_BLOCK_W-1:DES_HALF_W] ^ f_out};
    end

endmodule

// File: rtl/des_feistel_engine.sv
// Iterative DES Feistel datapath: UNROLL rounds per clock, valid/ready in and out,
// output is the swapped pre-output block {R_N, L_N}.
module des_feistel_engine
    import des_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = DES_ROUNDS,
    parameter int unsigned UNROLL     = 1,
    parameter int unsigned KEY_W      = DES_KEY_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DES_BLOCK_W-1:0]      in_block,
    input  logic                        in_decrypt,
    input  logic [NUM_ROUNDS*KEY_W-1:0] in_keys,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DES_BLOCK_W-1:0]      out_block,
    output logic                        busy
);

    localparam int unsigned STEPS = NUM_ROUNDS / UNROLL;
    localparam int unsigned CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    state_t                        state;
    logic [DES_BLOCK_W-1:0]        blk_q;
    logic [NUM_ROUNDS*KEY_W-1:0]   keys_q;
    logic                          decrypt_q;
    logic [CNT_W-1:0]              cnt;
    logic [DES_BLOCK_W-1:0]        chain [UNROLL+1];
    logic                          accept;

    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign busy     = (state == RUN);
    assign accept   = in_valid && in_ready;
    assign chain[0] = blk_q;

    for (genvar j = 0; j < UNROLL; j++) begin : g_slice
        logic [KEY_W-1:0] key;
        always_comb begin
            key = keys_q[KEY_W * key_index(32'(cnt) * UNROLL + 32'(j), decrypt_q, NUM_ROUNDS) +: KEY_W];
        end
        des_round_slice u_slice (
            .blk (chain[j]),
            .key (key),
            .nxt (chain[j+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            blk_q     <= '0;
            keys_q    <= '0;
            decrypt_q <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_block <= '0;
        end else if (accept) begin
            // Covers both IDLE and the same-edge hand-off from DONE.
            state     <= RUN;
            blk_q     <= in_block;
            keys_q    <= in_keys;
            decrypt_q <= in_decrypt;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    blk_q <= chain[UNROLL];
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        out_block <= {chain[UNROLL][DES_HALF_W-1:0],
                                      chain[UNROLL][DES_BLOCK_W-1:DES_HALF_W]};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/des_feistel_engine.md
Name: des_feistel_engine

Overview:
- Iterative, parametrised DES Feistel datapath with a valid/ready handshake on input and output.
- Runs NUM_ROUNDS Feistel rounds on a 64-bit {L,R} block, UNROLL rounds per clock, then applies the final L/R swap.
- Output is the pre-output block, ready for the final permutation.
- Sits between the initial-permutation stage and the final-permutation stage; round keys come from the key-schedule block.
- Supports encrypt and decrypt by reversing the order in which round keys are applied.

Parameters:
- NUM_ROUNDS, 16, total Feistel rounds per block; must be a multiple of UNROLL.
- UNROLL, 1, rounds computed combinationally per clock; legal values are 1, 2, 4, 8, 16.
- KEY_W, 48, width of one round key.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input block and keys valid
- in_ready  out  1  engine can accept a block
- in_block  in  64  {L0,R0}, L0 in [63:32]
- in_decrypt  in  1  0 = keys applied K1..KN, 1 = keys applied KN..K1
- in_keys  in  NUM_ROUNDS*KEY_W  packed round keys, K(i+1) at [KEY_W*i +: KEY_W]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_block  out  64  {R_N, L_N} (final swap applied)
- busy  out  1  high in RUN state

Behaviour:
- Reset (rst_n low at a clk edge): state = IDLE; out_valid = 0; busy = 0; out_block = 0; round counter = 0; internal state and key registers = 0.
- in_ready is a registered-state function: it is 1 in IDLE, and 1 in DONE when out_ready = 1. It is 0 in RUN.
- Accept occurs when in_valid and in_ready are both 1 at a clk edge. On accept, the engine:
  - latches in_block into the state register;
  - latches in_keys into the key registers;
  - latches in_decrypt into the mode register;
  - clears the round counter;
  - moves to RUN.
- Round selection in RUN: at counter value c, unrolled slice j (0..UNROLL-1) executes round r = c*UNROLL + j.
  - Key used: K(r+1) when encrypting, K(NUM_ROUNDS-r) when decrypting.
- Each slice performs L' = R; R' = L xor f(R, key). The slice output feeds the next slice combinationally within the cycle.
- The state register updates once per clock with the output of the last slice. The counter increments.
- When counter = NUM_ROUNDS/UNROLL - 1, the clock edge:
  - writes out_block = {R, L} of the final slice output (swap);
  - sets out_valid = 1;
  - moves to DONE.
- Latency: NUM_ROUNDS/UNROLL clocks from the accept edge to out_valid high.
  - UNROLL = 1 gives 16 cycles; UNROLL = 16 gives 1 cycle.
- DONE state:
  - out_valid and out_block are held stable until out_ready = 1.
  - out_ready = 1 with in_valid = 0: out_valid drops next edge; go to IDLE.
  - out_ready = 1 with in_valid = 1 in the same cycle: the new block is accepted and the state goes to RUN. out_valid drops at that edge, so back-to-back throughput is one block per (latency + 1) clocks.
- in_valid during RUN is ignored (in_ready = 0); the input is not captured. in_keys and in_block need only be stable at the accept edge.
- Changing in_decrypt or in_keys during RUN has no effect, because they are latched.
- Reset mid-operation: the block in flight is discarded, out_valid is 0 after that edge, and no partial result is ever presented.
- The counter width is clog2(NUM_ROUNDS/UNROLL) with a minimum of 1. When UNROLL = NUM_ROUNDS, RUN lasts exactly one cycle.

Decomposition:
- Shared package des_pkg holds:
  - DES_BLOCK_W = 64, DES_HALF_W = 32, DES_KEY_W = 48, DES_ROUNDS = 16;
  - the FSM state enum {IDLE, RUN, DONE};
  - a key-index helper function (round, decrypt, NUM_ROUNDS) -> key index.
- Natural sub-module: des_round_slice, one combinational Feistel round using the existing f-function. Instantiate it UNROLL times in a generate loop; the top keeps the FSM, counter and registers.

Test Plan:
- Encrypt, UNROLL = 1. Stimulus: in_block = 64'hCC00CCFF_F0AAF0AA, with K1..K16 from the key schedule of key 64'h133457799BBCDFF1 (K1 = 48'h1B02EFFC7072). Required: out_block = 64'h0A4CD995_43423234; out_valid rises exactly 16 clocks after accept; in_ready = 0 throughout RUN.
- Decrypt, same keys. Stimulus: in_block = 64'h0A4CD995_43423234, in_decrypt = 1. Required: out_block = 64'hCC00CCFF_F0AAF0AA.
- Parameter sweep over UNROLL = 2, 4, 16 with the same vectors. Required: identical results, with latency 8, 4 and 1 clocks respectively.
- Backpressure. Hold out_ready = 0 for 10 cycles after out_valid rises. Required: out_block and out_valid stay stable and in_ready stays 0; then out_ready = 1 with a new in_valid gives same-edge accept and the next result follows after the nominal latency.
- Reset mid-RUN. Assert rst_n = 0 at round 7. Required: out_valid = 0, in_ready = 1 and busy = 0 after reset. A fresh encrypt afterwards still produces 64'h0A4CD995_43423234.
- Ignored input. Pulse in_valid with a different block and keys during RUN. Required: the result is unchanged and the ignored block never appears on out_block.
